// File: rtl/multi_operand_sum_datapath_pkg.sv
// Shared definitions for the multi-operand sum datapath.
// - state_t     : sequencer states (IDLE, ACCUM, DONE)
// - MODE_ADD/SUB: values of the mode input
// - result_width: width that holds the worst-case add-mode sum without overflow
package multi_operand_sum_datapath_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // (NOPS+1)*(2^W-1) < 2^(W + clog2(NOPS+1)), so add mode can never wrap.
  function automatic int result_width(input int w, input int nops);
    return w + $clog2(nops + 1);
  endfunction

endpackage

// File: rtl/multi_operand_sum_datapath_operand_bank.sv
// Operand register bank: NOPS registers of W bits, loaded all at once.
// Ports:
// - clock : rising-edge clock
// - clear : asynchronous active-low reset, empties the bank
// - load  : capture every operand from d on this edge
// - d     : packed operands, d[i*W +: W] = operand i
// - sel   : read index
// - q     : combinational read of operand sel
module multi_operand_sum_datapath_operand_bank #(
  parameter int W    = 1,
  parameter int NOPS = 3,
  parameter int CW   = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              load,
  input  logic [NOPS*W-1:0] d,
  input  logic [CW-1:0]     sel,
  output logic [W-1:0]      q
);

  logic [W-1:0] bank [NOPS];

  // NOTE: the bank is a handful of flops, not a RAM macro, so it is cleared on
  // reset; a reset on a real memory array would block RAM inference.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NOPS; i++) bank[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NOPS; i++) bank[i] <= d[i*W +: W];
    end
  end

  // The sequencer only ever presents sel in 0..NOPS-1.
  assign q = bank[sel];

endmodule

// File: rtl/multi_operand_sum_datapath.sv
// Multi-operand sum datapath: adds (or subtracts) NOPS latched operands plus a
// carry/borrow-in through one shared adder, sequenced by a small FSM.
// Ports:
// - clock  : rising-edge clock
// - clear  : asynchronous active-low reset; aborts any operation in flight
// - start  : request, sampled only in IDLE
// - mode   : 0 = add, 1 = subtract (latched at start)
// - m      : operands, m[i*W +: W] = operand i (latched at start)
// - cin    : carry-in (add) / borrow-in (subtract), latched at start
// - busy   : high while accumulating
// - done   : one-cycle pulse when result becomes valid
// - result : final value, held until the next completion
// - neg    : sign of result in subtract mode, 0 in add mode
module multi_operand_sum_datapath
  import multi_operand_sum_datapath_pkg::*;
#(
  parameter int W    = 1,
  parameter int NOPS = 3,
  localparam int RW  = result_width(W, NOPS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              mode,
  input  logic [NOPS*W-1:0] m,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [RW-1:0]     result,
  output logic              neg
);

  localparam int CW = $clog2(NOPS);
  localparam logic [CW-1:0] LAST = CW'(NOPS - 1);

  state_t        state;
  logic [CW-1:0] count;
  logic [RW-1:0] acc;
  logic [RW-1:0] acc_next;
  logic          mode_q;
  logic          cin_q;
  logic [W-1:0]  op;
  logic [RW-1:0] op_ext;
  logic [RW-1:0] cin_ext;
  logic          load;

  assign load = (state == S_IDLE) && start;

  multi_operand_sum_datapath_operand_bank #(
    .W    (W),
    .NOPS (NOPS),
    .CW   (CW)
  ) u_bank (
    .clock (clock),
    .clear (clear),
    .load  (load),
    .d     (m),
    .sel   (count),
    .q     (op)
  );

  assign op_ext  = RW'(op);
  assign cin_ext = RW'(cin_q);

  // Shared adder/subtractor. The first step seeds acc from operand 0 so the
  // carry/borrow is folded in exactly once.
  // NOTE: acc_next gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    acc_next = acc;
    if (mode_q == MODE_ADD) begin
      acc_next = acc + op_ext + ((count == '0) ? cin_ext : '0);
    end else if (count == '0) begin
      acc_next = op_ext - cin_ext;
    end else begin
      acc_next = acc - op_ext;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state  <= S_IDLE;
      count  <= '0;
      acc    <= '0;
      mode_q <= MODE_ADD;
      cin_q  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      neg    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            cin_q  <= cin;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            // Final step: publish the freshly computed value on DONE entry.
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= acc_next;
            neg    <= (mode_q == MODE_SUB) && acc_next[RW-1];
            state  <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_operand_sum_datapath.sv
// Directed self-checking bench for multi_operand_sum_datapath.
// Two instances: u_a (W=1, NOPS=3, RW=3) and u_b (W=4, NOPS=4, RW=7).
module tb_multi_operand_sum_datapath;

  logic clock;
  logic clear;

  logic       start_a, mode_a, cin_a;
  logic [2:0] m_a;
  logic       busy_a, done_a, neg_a;
  logic [2:0] result_a;

  logic        start_b, mode_b, cin_b;
  logic [15:0] m_b;
  logic        busy_b, done_b, neg_b;
  logic [6:0]  result_b;

  int n_checks = 0;
  int n_pass   = 0;

  multi_operand_sum_datapath #(.W(1), .NOPS(3)) u_a (
    .clock  (clock),
    .clear  (clear),
    .start  (start_a),
    .mode   (mode_a),
    .m      (m_a),
    .cin    (cin_a),
    .busy   (busy_a),
    .done   (done_a),
    .result (result_a),
    .neg    (neg_a)
  );

  multi_operand_sum_datapath #(.W(4), .NOPS(4)) u_b (
    .clock  (clock),
    .clear  (clear),
    .start  (start_b),
    .mode   (mode_b),
    .m      (m_b),
    .cin    (cin_b),
    .busy   (busy_b),
    .done   (done_b),
    .result (result_b),
    .neg    (neg_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  // Pulse start on u_a, then wait (bounded) for done. edges counts clock edges
  // from the start edge up to the one that raises done; busy_cnt counts cycles
  // with busy high. Returns one cycle after the done cycle (back in IDLE).
  task automatic run_a(input logic [2:0] mv, input logic md, input logic ci,
                       output int edges, output int busy_cnt);
    m_a = mv; mode_a = md; cin_a = ci; start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    edges = 1; busy_cnt = 0;
    while (!done_a && edges < 20) begin
      if (busy_a) busy_cnt++;
      @(posedge clock); #1;
      edges++;
    end
    @(posedge clock); #1;
  endtask

  task automatic run_b(input logic [15:0] mv, input logic md, input logic ci,
                       output int edges, output int busy_cnt);
    m_b = mv; mode_b = md; cin_b = ci; start_b = 1'b1;
    @(posedge clock); #1;
    start_b = 1'b0;
    edges = 1; busy_cnt = 0;
    while (!done_b && edges < 20) begin
      if (busy_b) busy_cnt++;
      @(posedge clock); #1;
      edges++;
    end
    @(posedge clock); #1;
  endtask

  initial begin
    int edges, busy_cnt, t, first, second;
    bit seen_done;

    clear = 1'b0;
    start_a = 1'b0; mode_a = 1'b0; cin_a = 1'b0; m_a = '0;
    start_b = 1'b0; mode_b = 1'b0; cin_b = 1'b0; m_b = '0;

    // Reset state
    #12;
    check("reset_busy",   busy_a,   0);
    check("reset_done",   done_a,   0);
    check("reset_result", result_a, 0);
    check("reset_neg",    neg_a,    0);
    check("reset_b_result", result_b, 0);
    check("reset_b_busy",   busy_b,   0);
    clear = 1'b1;
    @(posedge clock); #1;

    // add op0=1 op1=0 op2=1, cin=1 -> 3
    run_a(3'b101, 1'b0, 1'b1, edges, busy_cnt);
    check("add101_result",  result_a, 3);
    check("add101_neg",     neg_a,    0);
    check("add101_latency", edges,    4);
    check("add101_busy",    busy_cnt, 3);
    // result holds after done
    @(posedge clock); #1;
    check("hold_result", result_a, 3);
    check("hold_done",   done_a,   0);

    // add all ones, cin=1 -> 4 (MSB set, still neg=0 in add mode)
    run_a(3'b111, 1'b0, 1'b1, edges, busy_cnt);
    check("add111_result", result_a, 4);
    check("add111_busy",   busy_cnt, 3);
    check("add111_neg",    neg_a,    0);

    // sub op0=0 op1=1 op2=0, cin=1 -> 0-1-1-0 = -2 = 3'b110
    run_a(3'b010, 1'b1, 1'b1, edges, busy_cnt);
    check("sub010_result", result_a, 6);
    check("sub010_neg",    neg_a,    1);

    // sub op0=1 others 0, cin=0 -> 1, non-negative
    run_a(3'b001, 1'b1, 1'b0, edges, busy_cnt);
    check("sub001_result", result_a, 1);
    check("sub001_neg",    neg_a,    0);

    // W=4 NOPS=4: 4*15 + 1 = 61
    run_b(16'hFFFF, 1'b0, 1'b1, edges, busy_cnt);
    check("b_add_result",  result_b, 61);
    check("b_add_latency", edges,    5);
    check("b_add_busy",    busy_cnt, 4);
    check("b_add_neg",     neg_b,    0);

    // Abort with reset while count==1
    m_a = 3'b111; mode_a = 1'b0; cin_a = 1'b1; start_a = 1'b1;
    @(posedge clock); #1;     // start edge -> ACCUM, count 0
    start_a = 1'b0;
    @(posedge clock); #1;     // count 1
    check("abort_pre_busy", busy_a, 1);
    clear = 1'b0;
    #1;
    check("abort_busy",   busy_a,   0);
    check("abort_result", result_a, 0);
    check("abort_done",   done_a,   0);
    check("abort_neg",    neg_a,    0);
    @(negedge clock);
    clear = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (done_a) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    run_a(3'b011, 1'b0, 1'b0, edges, busy_cnt);
    check("after_abort_result", result_a, 2);

    // start re-pulsed and inputs changed during ACCUM are ignored
    m_a = 3'b001; mode_a = 1'b0; cin_a = 1'b0; start_a = 1'b1;
    @(posedge clock); #1;
    m_a = 3'b111; mode_a = 1'b1; cin_a = 1'b1; start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    t = 0;
    while (!done_a && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    check("ignore_result", result_a, 1);
    check("ignore_neg",    neg_a,    0);
    @(posedge clock); #1;

    // start held high: one operation every NOPS+2 = 5 cycles
    m_a = 3'b001; mode_a = 1'b0; cin_a = 1'b0; start_a = 1'b1;
    t = 0; first = -1; second = -1;
    while (t < 40 && second < 0) begin
      @(posedge clock); #1;
      t++;
      if (done_a) begin
        if (first < 0) first = t;
        else second = t;
      end
    end
    start_a = 1'b0;
    check("b2b_period", second - first, 5);
    check("b2b_result", result_a, 1);
    @(posedge clock); #1;
    @(posedge clock); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
